// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator for RV32/RV64 instructions.
// Accepts a raw 32-bit instruction plus an opaque tag over valid/ready,
// decodes the immediate format from the opcode and returns the immediate
// extended to XLEN bits one cycle later. A two-entry arrangement (output
// register + skid register) keeps full throughput while in_ready comes
// straight from a flop.
//
// Optional build macro: IMMGEN_ZIMM_EN
//   defined   -> SYSTEM opcodes with funct3 != 0 decode as type Z (CSR uimm,
//                zero-extended); SYSTEM with funct3 == 0 decodes as type I.
//   undefined -> every SYSTEM opcode is reported as illegal (type NONE).

module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Immediate format encodings reported on out_type.
    localparam logic [2:0] TYPE_I    = 3'd0;
    localparam logic [2:0] TYPE_S    = 3'd1;
    localparam logic [2:0] TYPE_B    = 3'd2;
    localparam logic [2:0] TYPE_U    = 3'd3;
    localparam logic [2:0] TYPE_J    = 3'd4;
`ifdef IMMGEN_ZIMM_EN
    localparam logic [2:0] TYPE_Z    = 3'd5;
`endif
    localparam logic [2:0] TYPE_NONE = 3'd7;

    // Major opcodes that carry an immediate.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMMGEN_ZIMM_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    // Only 32- and 64-bit datapaths are meaningful; anything else stops elaboration.
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      dec_op;
    logic [31:0]     dec_imm32;
    logic            dec_sext;
    logic [2:0]      dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    assign dec_op = in_instr[6:0];

    // Select the immediate layout from the opcode; unknown opcodes yield a clean zero.
    always_comb begin
        dec_imm32   = '0;
        dec_sext    = 1'b0;
        dec_type    = TYPE_NONE;
        dec_illegal = 1'b1;
        case (dec_op)
            OP_LOAD, OP_IMM, OP_JALR: begin
                dec_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_sext    = 1'b1;
                dec_type    = TYPE_I;
                dec_illegal = 1'b0;
            end
            OP_STORE: begin
                dec_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_sext    = 1'b1;
                dec_type    = TYPE_S;
                dec_illegal = 1'b0;
            end
            OP_BRANCH: begin
                dec_imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
                dec_sext    = 1'b1;
                dec_type    = TYPE_B;
                dec_illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm32   = {in_instr[31:12], 12'b0};
                dec_sext    = 1'b1;
                dec_type    = TYPE_U;
                dec_illegal = 1'b0;
            end
            OP_JAL: begin
                dec_imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
                dec_sext    = 1'b1;
                dec_type    = TYPE_J;
                dec_illegal = 1'b0;
            end
`ifdef IMMGEN_ZIMM_EN
            OP_SYSTEM: begin
                dec_illegal = 1'b0;
                if (in_instr[14:12] != 3'b000) begin
                    // CSR immediate forms: the rs1 field is an unsigned 5-bit value.
                    dec_imm32 = {27'b0, in_instr[19:15]};
                    dec_sext  = 1'b0;
                    dec_type  = TYPE_Z;
                end else begin
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_sext  = 1'b1;
                    dec_type  = TYPE_I;
                end
            end
`endif
            default: begin
                dec_imm32   = '0;
                dec_sext    = 1'b0;
                dec_type    = TYPE_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Low word comes straight from the decoder; upper bits (RV64 only) replicate instr[31]
    // for sign-extended formats and stay zero for Z/NONE.
    assign dec_imm[31:0] = dec_imm32;
    generate
        for (genvar gi = 32; gi < XLEN; gi++) begin : g_ext
            assign dec_imm[gi] = dec_sext & in_instr[31];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    logic             out_valid_q,   out_valid_d;
    logic [XLEN-1:0]  out_imm_q,     out_imm_d;
    logic [2:0]       out_type_q,    out_type_d;
    logic             out_illegal_q, out_illegal_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;

    logic             skid_valid_q,   skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,     skid_imm_d;
    logic [2:0]       skid_type_q,    skid_type_d;
    logic             skid_illegal_q, skid_illegal_d;
    logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;

    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             out_free;

    assign accept   = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    // Next-state for the two entries; the skid entry always drains ahead of new input.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_type_d     = out_type_q;
        out_illegal_d  = out_illegal_q;
        out_tag_d      = out_tag_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_type_d    = skid_type_q;
        skid_illegal_d = skid_illegal_q;
        skid_tag_d     = skid_tag_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_type_d    = skid_type_q;
                out_illegal_d = skid_illegal_q;
                out_tag_d     = skid_tag_q;
                skid_valid_d  = accept;
                if (accept) begin
                    skid_imm_d     = dec_imm;
                    skid_type_d    = dec_type;
                    skid_illegal_d = dec_illegal;
                    skid_tag_d     = in_tag;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_imm_d     = dec_imm;
                    out_type_d    = dec_type;
                    out_illegal_d = dec_illegal;
                    out_tag_d     = in_tag;
                end
            end
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_type_d    = dec_type;
            skid_illegal_d = dec_illegal;
            skid_tag_d     = in_tag;
        end

        // Ready for the next cycle is simply "skid will be empty".
        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous reset that drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_type_q     <= TYPE_NONE;
            out_illegal_q  <= 1'b0;
            out_tag_q      <= '0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_type_q    <= TYPE_NONE;
            skid_illegal_q <= 1'b0;
            skid_tag_q     <= '0;
            in_ready_q     <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_type_q     <= out_type_d;
            out_illegal_q  <= out_illegal_d;
            out_tag_q      <= out_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_type_q    <= skid_type_d;
            skid_illegal_q <= skid_illegal_d;
            skid_tag_q     <= skid_tag_d;
            in_ready_q     <= in_ready_d;
        end
    end

    // The ready flop resets to 1 so the stage accepts on the first cycle after reset;
    // it is masked while reset is held so nothing is offered as accepted meanwhile.
    assign in_ready    = in_ready_q & ~reset;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_type    = out_type_q;
    assign out_illegal = out_illegal_q;
    assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance share the
// same stimulus; a scoreboard queue holds expected results from a constant
// vector table and is compared whenever an output is presented.

module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  tag;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready,   in_ready64;
    logic        out_valid,  out_valid64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;
    logic [2:0]  out_type,   out_type64;
    logic        out_illegal, out_illegal64;
    logic [7:0]  out_tag,    out_tag64;

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_type(out_type),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_type(out_type64),
        .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_deliv = 0;
    vec_t vecs [13];
    vec_t cur_exp;
    vec_t sb_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [7:0] tag,
                                input logic [31:0] imm32, input logic [63:0] imm64,
                                input logic [2:0] typ, input logic ill);
        vec_t v;
        v.instr = instr; v.tag = tag; v.imm32 = imm32; v.imm64 = imm64;
        v.typ = typ; v.ill = ill;
        return v;
    endfunction

    // Scoreboard: compare whatever is presented, pop on transfer, push on accept.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    vec_t e;
                    e = sb_q[0];
                    chk("imm32",    {32'b0, out_imm}, {32'b0, e.imm32});
                    chk("type",     {61'b0, out_type}, {61'b0, e.typ});
                    chk("illegal",  {63'b0, out_illegal}, {63'b0, e.ill});
                    chk("tag",      {56'b0, out_tag}, {56'b0, e.tag});
                    chk("valid64",  {63'b0, out_valid64}, 64'd1);
                    chk("imm64",    out_imm64, e.imm64);
                    chk("type64",   {61'b0, out_type64}, {61'b0, e.typ});
                    chk("tag64",    {56'b0, out_tag64}, {56'b0, e.tag});
                    $display("out tag=0x%02h instr=0x%08h imm32=0x%08h imm64=0x%016h type=%0d ill=%0b ready=%0b",
                             out_tag, e.instr, out_imm, out_imm64, out_type, out_illegal, out_ready);
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        n_deliv++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_exp);
                n_acc++;
                $display("in  tag=0x%02h instr=0x%08h accepted", cur_exp.tag, cur_exp.instr);
            end
        end
    end

    // Present one vector until accepted; optionally toggle out_ready randomly while waiting.
    task automatic send(input int idx, input bit rnd, output int waits);
        bit done;
        in_valid = 1'b1;
        in_instr = vecs[idx].instr;
        in_tag   = vecs[idx].tag;
        cur_exp  = vecs[idx];
        waits    = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 60) begin
                    n_vec++; n_err++;
                    $display("FAIL send_timeout: tag 0x%02h not accepted, in_ready=%0b required 1",
                             vecs[idx].tag, in_ready);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int w, wsum, d0, a0;

        vecs[0]  = mk(32'hFFF00093, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        vecs[1]  = mk(32'hFE112E23, 8'h12, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        vecs[2]  = mk(32'h00000863, 8'h13, 32'h00000010, 64'h0000000000000010, 3'd2, 1'b0);
        vecs[3]  = mk(32'h123452B7, 8'h14, 32'h12345000, 64'h0000000012345000, 3'd3, 1'b0);
        vecs[4]  = mk(32'hFF9FF06F, 8'h15, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd4, 1'b0);
        vecs[5]  = mk(32'h800002B7, 8'h16, 32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
        vecs[6]  = mk(32'h00000033, 8'h17, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1);
`ifdef IMMGEN_ZIMM_EN
        vecs[7]  = mk(32'h3402A073, 8'h18, 32'h00000005, 64'h0000000000000005, 3'd5, 1'b0);
        vecs[8]  = mk(32'h00100073, 8'h19, 32'h00000001, 64'h0000000000000001, 3'd0, 1'b0);
`else
        vecs[7]  = mk(32'h3402A073, 8'h18, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1);
        vecs[8]  = mk(32'h00100073, 8'h19, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1);
`endif
        vecs[9]  = mk(32'h80002083, 8'h1A, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd0, 1'b0);
        vecs[10] = mk(32'h00008067, 8'h1B, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0);
        vecs[11] = mk(32'hFFFFF117, 8'h1C, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd3, 1'b0);
        vecs[12] = mk(32'hFE000FE3, 8'h1D, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd2, 1'b0);

        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
        cur_exp = vecs[0];

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready",  {63'b0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_imm",   {32'b0, out_imm}, 64'd0);
        chk("rst_out_imm64", out_imm64, 64'd0);
        chk("rst_out_type",  {61'b0, out_type}, 64'd7);
        chk("rst_out_ill",   {63'b0, out_illegal}, 64'd0);
        chk("rst_out_tag",   {56'b0, out_tag}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Single addi, then one-cycle latency check
        out_ready = 1'b1;
        send(0, 1'b0, w);
        @(negedge clk);
        chk("addi_latency_valid", {63'b0, out_valid}, 64'd1);
        @(posedge clk); #1;

        // Format sweep back-to-back: no stalls, one result per cycle
        wsum = 0;
        d0 = n_deliv;
        for (int i = 1; i <= 4; i++) begin
            send(i, 1'b0, w);
            wsum += w;
        end
        chk("sweep_stalls", 64'(wsum), 64'd0);
        @(posedge clk); #2;
        chk("sweep_delivered", 64'(n_deliv - d0), 64'd4);

        // Remaining table with random backpressure
        for (int i = 5; i < 13; i++) send(i, 1'b1, w);
        drain(40);

        // Backpressure: only two accepted while out_ready=0
        out_ready = 1'b0;
        a0 = n_acc;
        d0 = n_deliv;
        in_valid = 1'b1; in_instr = vecs[9].instr; in_tag = vecs[9].tag; cur_exp = vecs[9];
        @(negedge clk);
        chk("bp_ready_1", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_instr = vecs[10].instr; in_tag = vecs[10].tag; cur_exp = vecs[10];
        @(negedge clk);
        chk("bp_ready_2", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_instr = vecs[11].instr; in_tag = vecs[11].tag; cur_exp = vecs[11];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready_full", {63'b0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(n_acc - a0), 64'd2);
        out_ready = 1'b1;
        send(11, 1'b0, w);
        send(12, 1'b0, w);
        drain(20);
        chk("bp_delivered", 64'(n_deliv - d0), 64'd4);

        // Reset with both entries full: nothing stale may come out
        out_ready = 1'b0;
        send(3, 1'b0, w);
        send(4, 1'b0, w);
        @(negedge clk);
        chk("full_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_in_ready1", {63'b0, in_ready}, 64'd1);
        chk("midrst_type",      {61'b0, out_type}, 64'd7);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        send(6, 1'b0, w);
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
